seg7_scan_controller: RTL and testbench

- Drives the multiplexed 7-segment display from a 16-bit binary value, such as the game's target count.
- Accepts a value through a valid/busy handshake and converts it to BCD sequentially (double dabble, one bit per clock), so no combinational divide/modulo is needed.
- Scans the digits with a per-slot dead time to suppress ghosting; optionally blanks leading zeros.
- Sits between game_top and the board abcdefgh/digit pins.

---
 rtl/seg7_scan_controller_if.sv | 13 +
 rtl/seg7_scan_controller.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_controller_if.sv
// Value/handshake bundle between the game logic and the 7-segment scan controller.
interface seg7_scan_controller_if;
    logic [15:0] value;
    logic        value_valid;
    logic        blank_lz;
    logic        busy;
    logic        overflow;

    modport master (output value, output value_valid, output blank_lz,
                    input busy, input overflow);
    modport slave  (input value, input value_valid, input blank_lz,
                    output busy, output overflow);
endinterface

// File: rtl/seg7_scan_controller.sv
// Binary-to-BCD (double dabble, one bit per clock) feeding a multiplexed
// 7-segment scanner with per-slot dead time and optional leading-zero blanking.
module seg7_scan_controller #(
    parameter int w_digit      = 8,
    parameter int n_digits     = 4,
    parameter int slot_cycles  = 50000,
    parameter int blank_cycles = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_scan_controller_if.slave  bus,
    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit
);
    localparam int CW = (slot_cycles > 1) ? $clog2(slot_cycles) : 1;
    localparam int IW = (n_digits > 1) ? $clog2(n_digits) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t               state_q, state_d;
    logic [15:0]          shift_q, shift_d;
    logic [19:0]          accum_q, accum_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [19:0]          display_q, display_d;
    logic                 overflow_q, overflow_d;
    logic                 pending_q, pending_d;
    logic [15:0]          pending_value_q, pending_value_d;
    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           seg_q, seg_d;
    logic [w_digit-1:0]   digit_q, digit_d;

    logic [19:0]          adj;
    logic                 ovf_new;
    logic                 lz_zero;
    logic [3:0]           nib;

    function automatic logic [7:0] seg_pattern(input logic [3:0] n);
        case (n)
            4'd0:    seg_pattern = 8'hFC;
            4'd1:    seg_pattern = 8'h60;
            4'd2:    seg_pattern = 8'hDA;
            4'd3:    seg_pattern = 8'hF2;
            4'd4:    seg_pattern = 8'h66;
            4'd5:    seg_pattern = 8'hB6;
            4'd6:    seg_pattern = 8'hBE;
            4'd7:    seg_pattern = 8'hE0;
            4'd8:    seg_pattern = 8'hFE;
            4'd9:    seg_pattern = 8'hF6;
            default: seg_pattern = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        accum_d         = accum_q;
        bit_cnt_d       = bit_cnt_q;
        display_d       = display_q;
        overflow_d      = overflow_q;
        pending_d       = pending_q;
        pending_value_d = pending_value_q;
        adj             = accum_q;
        ovf_new         = 1'b0;
        for (int k = n_digits; k < 5; k++) begin
            if (accum_q[4*k +: 4] != 4'd0) ovf_new = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (bus.value_valid) begin
                    shift_d   = bus.value;
                    accum_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                for (int k = 0; k < 5; k++) begin
                    if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
                end
                {accum_d, shift_d} = {adj, shift_q} << 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) state_d = COMMIT;
                if (bus.value_valid) begin
                    pending_d       = 1'b1;
                    pending_value_d = bus.value;
                end
            end
            COMMIT: begin
                display_d  = accum_q;
                overflow_d = ovf_new;
                // A strobe landing on the commit cycle is newer than any stored pending value.
                if (bus.value_valid || pending_q) begin
                    shift_d   = bus.value_valid ? bus.value : pending_value_q;
                    accum_d   = '0;
                    bit_cnt_d = '0;
                    pending_d = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(slot_cycles - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(n_digits - 1)) ? '0 : idx_q + IW'(1);
        end
        // Decode from the next display value so a commit shows up without an extra cycle.
        nib     = display_d[{idx_q, 2'b00} +: 4];
        lz_zero = 1'b1;
        for (int k = 0; k < n_digits; k++) begin
            if (k >= int'(idx_q) && display_d[4*k +: 4] != 4'd0) lz_zero = 1'b0;
        end
        seg_d   = 8'hFF;
        digit_d = '0;
        if (cnt_q >= CW'(blank_cycles)) begin
            digit_d = w_digit'(1) << idx_q;
            if (overflow_d)
                seg_d = ~8'h02;
            else if (bus.blank_lz && idx_q != '0 && lz_zero)
                seg_d = 8'hFF;
            else
                seg_d = ~seg_pattern(nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            accum_q         <= '0;
            bit_cnt_q       <= '0;
            display_q       <= '0;
            overflow_q      <= 1'b0;
            pending_q       <= 1'b0;
            pending_value_q <= '0;
            busy_q          <= 1'b0;
            cnt_q           <= '0;
            idx_q           <= '0;
            seg_q           <= 8'hFF;
            digit_q         <= '0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            accum_q         <= accum_d;
            bit_cnt_q       <= bit_cnt_d;
            display_q       <= display_d;
            overflow_q      <= overflow_d;
            pending_q       <= pending_d;
            pending_value_q <= pending_value_d;
            busy_q          <= busy_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            seg_q           <= seg_d;
            digit_q         <= digit_d;
        end
    end

    assign abcdefgh     = seg_q;
    assign digit        = digit_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: reset, scan timing, BCD display,
// blanking, overflow, back-to-back strobes and mid-conversion reset.
module tb_seg7_scan_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] abcdefgh;
    logic [7:0] digit;
    int         checks = 0;
    int         errors = 0;

    seg7_scan_controller_if bus();

    seg7_scan_controller #(
        .w_digit(8), .n_digits(4), .slot_cycles(20), .blank_cycles(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .abcdefgh(abcdefgh), .digit(digit)
    );

    always #5 clk = ~clk;

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        bus.value       = v;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Gathers the segment byte seen in each slot 0..3; ok bit clear means that slot never appeared.
    task automatic capture_slots(output logic [31:0] segs, output logic [3:0] ok);
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (digit !== (8'h01 << i) && n < 200) begin
                @(negedge clk);
                n++;
            end
            ok[i]          = (n < 200);
            segs[8*i +: 8] = abcdefgh;
        end
    endtask

    task automatic test_reset;
        logic [31:0] segs;
        logic [3:0]  ok;
        logic [31:0] exp;
        int          n;
        bus.value = '0; bus.value_valid = 1'b0; bus.blank_lz = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (digit !== 8'h00) begin errors++; $display("[TB] FAIL reset_digit: got %h expected 00", digit); end
        checks++; if (abcdefgh !== 8'hFF) begin errors++; $display("[TB] FAIL reset_seg: got %h expected FF", abcdefgh); end
        rst = 1'b0;
        n = 0;
        while (digit !== 8'h01 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n >= 200) begin errors++; $display("[TB] FAIL scan_start: digit 01 not seen"); end
        n = 0;
        while (digit === 8'h01 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL slot_on_len: got %0d expected 16", n); end
        n = 0;
        while (digit === 8'h00 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n !== 4) begin errors++; $display("[TB] FAIL slot_blank_len: got %0d expected 4", n); end
        checks++; if (digit !== 8'h02) begin errors++; $display("[TB] FAIL scan_next: got %h expected 02", digit); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] want;
            want = 8'h04 << i;
            if (i == 2) want = 8'h01;
            n = 0;
            while (digit !== 8'h00 && n < 200) begin @(negedge clk); n++; end
            checks++; if (abcdefgh !== 8'hFF) begin errors++; $display("[TB] FAIL blank_seg: got %h expected FF", abcdefgh); end
            while (digit === 8'h00 && n < 200) begin @(negedge clk); n++; end
            checks++; if (digit !== want) begin errors++; $display("[TB] FAIL scan_seq: got %h expected %h", digit, want); end
        end
        exp = 32'h03030303;
        capture_slots(segs, ok);
        checks++; if (ok !== 4'hF) begin errors++; $display("[TB] FAIL reset_slots_seen: got %b expected 1111", ok); end
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL reset_display: got %h expected %h", segs, exp); end
    endtask

    task automatic test_convert;
        logic [31:0] segs;
        logic [3:0]  ok;
        logic [31:0] exp;
        int          n;
        bus.blank_lz = 1'b0;
        strobe(16'd1234);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise: got %b expected 1", bus.busy); end
        wait_idle(n);
        checks++; if (n !== 17) begin errors++; $display("[TB] FAIL busy_len_1234: got %0d expected 17", n); end
        exp = 32'h9F250D99;
        capture_slots(segs, ok);
        checks++; if (ok !== 4'hF) begin errors++; $display("[TB] FAIL slots_1234: got %b expected 1111", ok); end
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL display_1234: got %h expected %h", segs, exp); end
    endtask

    task automatic test_blank_lz;
        logic [31:0] segs;
        logic [3:0]  ok;
        logic [31:0] exp;
        int          n;
        bus.blank_lz = 1'b1;
        strobe(16'd7);
        wait_idle(n);
        exp = 32'hFFFFFF1F;
        capture_slots(segs, ok);
        checks++; if (ok !== 4'hF) begin errors++; $display("[TB] FAIL lz_enables_7: got %b expected 1111", ok); end
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL lz_display_7: got %h expected %h", segs, exp); end
        strobe(16'd0);
        wait_idle(n);
        exp = 32'hFFFFFF03;
        capture_slots(segs, ok);
        checks++; if (ok !== 4'hF) begin errors++; $display("[TB] FAIL lz_enables_0: got %b expected 1111", ok); end
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL lz_display_0: got %h expected %h", segs, exp); end
        strobe(16'd1030);
        wait_idle(n);
        exp = 32'h9F030D03;
        capture_slots(segs, ok);
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL lz_inner_zero: got %h expected %h", segs, exp); end
    endtask

    task automatic test_overflow;
        logic [31:0] segs;
        logic [3:0]  ok;
        logic [31:0] exp;
        int          n;
        bus.blank_lz = 1'b1;
        strobe(16'd10000);
        wait_idle(n);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", bus.overflow); end
        exp = 32'hFDFDFDFD;
        capture_slots(segs, ok);
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL ovf_display: got %h expected %h", segs, exp); end
        bus.blank_lz = 1'b0;
        strobe(16'd9999);
        wait_idle(n);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", bus.overflow); end
        exp = 32'h09090909;
        capture_slots(segs, ok);
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL display_9999: got %h expected %h", segs, exp); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] segs;
        logic [3:0]  ok;
        logic [31:0] exp;
        int          n;
        bus.blank_lz = 1'b0;
        strobe(16'd11);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (n == 2)      begin bus.value = 16'd22; bus.value_valid = 1'b1; end
            else if (n == 4) begin bus.value = 16'd33; bus.value_valid = 1'b1; end
            else             bus.value_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.value_valid = 1'b0;
        checks++; if (n !== 34) begin errors++; $display("[TB] FAIL b2b_busy_len: got %0d expected 34", n); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_extra_reload: got %b expected 0", bus.busy); end
        exp = 32'h03030D0D;
        capture_slots(segs, ok);
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL b2b_display: got %h expected %h", segs, exp); end
    endtask

    task automatic test_reset_mid_shift;
        logic [31:0] segs;
        logic [3:0]  ok;
        logic [31:0] exp;
        bus.blank_lz = 1'b0;
        strobe(16'd5678);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        checks++; if (digit !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_digit: got %h expected 00", digit); end
        checks++; if (abcdefgh !== 8'hFF) begin errors++; $display("[TB] FAIL rst_mid_seg: got %h expected FF", abcdefgh); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_aborted: got %b expected 0", bus.busy); end
        exp = 32'h03030303;
        capture_slots(segs, ok);
        checks++; if (segs !== exp) begin errors++; $display("[TB] FAIL rst_mid_display: got %h expected %h", segs, exp); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blank_lz();
        test_overflow();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
